// File: rtl/pong_pkg.sv
// Shared constants, FSM state type and heading reflection helpers for the pong ball engine.
package pong_pkg;

  localparam int unsigned THETA_WIDTH = 6;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned BALL_SIZE   = 8;
  localparam int unsigned FRAC        = 7;
  localparam int unsigned POS_W       = 10;
  localparam int unsigned LUT_W       = 8;
  localparam int unsigned SPEED_W     = 3;
  localparam int unsigned ACC_W       = POS_W + FRAC;
  // sext(lut) * speed spans -896..889, which fits 11 signed bits
  localparam int unsigned STEP_W      = 11;

  localparam int unsigned X_MAX    = SCREEN_W - BALL_SIZE;
  localparam int unsigned Y_MAX    = SCREEN_H - BALL_SIZE;
  localparam int unsigned X_CENTRE = X_MAX / 2;
  localparam int unsigned Y_CENTRE = Y_MAX / 2;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_e;

  // Reflection off a horizontal wall: negate the angle
  function automatic logic [THETA_WIDTH-1:0] reflect_v(input logic [THETA_WIDTH-1:0] theta);
    return THETA_WIDTH'(0) - theta;
  endfunction

  // Reflection off a vertical paddle: pi minus the angle
  function automatic logic [THETA_WIDTH-1:0] reflect_h(input logic [THETA_WIDTH-1:0] theta);
    return THETA_WIDTH'(1 << (THETA_WIDTH - 1)) - theta;
  endfunction

endpackage

// File: rtl/ball_axis.sv
// One-axis fixed-point position accumulator with signed step and clamping.
//   clk_i, reset_i : clock, synchronous active-high reset (to centre)
//   load_i         : reload the centre position
//   step_en_i      : apply step_i this cycle (with clamping)
//   step_i         : signed step in 2^-FRAC pixel units
//   pos_o          : registered integer position
//   lo_c_o, hi_c_o : combinational flags, position + step leaves [0, LIMIT]
module ball_axis
  import pong_pkg::*;
#(
  parameter int unsigned LIMIT  = X_MAX,
  parameter int unsigned CENTRE = X_CENTRE
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     load_i,
  input  logic                     step_en_i,
  input  logic signed [STEP_W-1:0] step_i,
  output logic [POS_W-1:0]         pos_o,
  output logic                     lo_c_o,
  output logic                     hi_c_o
);

  localparam int unsigned NXT_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] MAX_FX    = ACC_W'(LIMIT << FRAC);
  localparam logic [ACC_W-1:0] CENTRE_FX = ACC_W'(CENTRE << FRAC);

  logic [ACC_W-1:0]        pos_q, pos_d;
  logic signed [NXT_W-1:0] next_c;

  // Candidate position with a guard bit so underflow shows as negative
  always_comb begin
    next_c = $signed({1'b0, pos_q}) + NXT_W'(step_i);
    lo_c_o = next_c[NXT_W-1];
    hi_c_o = !next_c[NXT_W-1] && (next_c > $signed({1'b0, MAX_FX}));
    pos_d  = pos_q;
    if (load_i) begin
      pos_d = CENTRE_FX;
    end else if (step_en_i) begin
      if (lo_c_o)      pos_d = '0;
      else if (hi_c_o) pos_d = MAX_FX;
      else             pos_d = next_c[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) pos_q <= CENTRE_FX;
    else         pos_q <= pos_d;
  end

  assign pos_o = pos_q[ACC_W-1:FRAC];

endmodule

// File: rtl/ball_motion.sv
// Frame-rate ball kinematics: heading register, serve/goal FSM and two axis integrators.
//   CLK, reset          : clock, synchronous active-high reset
//   tick_i              : frame strobe, integrates one step while moving
//   start_i             : serve (centre ball, load theta_i and speed_i)
//   paddle_hit_i        : paddle collision, reflects heading
//   theta_o             : heading to the LUT; sin_i/cos_i return combinationally
//   ball_x_o, ball_y_o  : integer top-left position
//   active_o            : ball in play
//   bounce_o, goal_*_o  : one-cycle event pulses
module ball_motion
  import pong_pkg::*;
(
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    tick_i,
  input  logic                    start_i,
  input  logic [THETA_WIDTH-1:0]  theta_i,
  input  logic [SPEED_W-1:0]      speed_i,
  input  logic                    paddle_hit_i,
  output logic [THETA_WIDTH-1:0]  theta_o,
  input  logic signed [LUT_W-1:0] sin_i,
  input  logic signed [LUT_W-1:0] cos_i,
  output logic [POS_W-1:0]        ball_x_o,
  output logic [POS_W-1:0]        ball_y_o,
  output logic                    active_o,
  output logic                    bounce_o,
  output logic                    goal_left_o,
  output logic                    goal_right_o
);

  state_e                  state_q;
  logic [THETA_WIDTH-1:0]  theta_q;
  logic [SPEED_W-1:0]      speed_q;
  logic                    active_q, bounce_q, goal_l_q, goal_r_q;

  logic signed [STEP_W-1:0] speed_s_c, dx_c, dy_c;
  logic                     step_en_c;
  logic                     x_lo_c, x_hi_c, y_lo_c, y_hi_c;

  // Per-tick step; a same-cycle serve or paddle hit suppresses integration
  always_comb begin
    speed_s_c = $signed({{(STEP_W - SPEED_W){1'b0}}, speed_q});
    dx_c      = STEP_W'(cos_i) * speed_s_c;
    dy_c      = STEP_W'(sin_i) * speed_s_c;
    step_en_c = (state_q == MOVE) && tick_i && !paddle_hit_i && !start_i;
  end

  ball_axis #(.LIMIT(X_MAX), .CENTRE(X_CENTRE)) u_axis_x (
    .clk_i    (CLK),
    .reset_i  (reset),
    .load_i   (start_i),
    .step_en_i(step_en_c),
    .step_i   (dx_c),
    .pos_o    (ball_x_o),
    .lo_c_o   (x_lo_c),
    .hi_c_o   (x_hi_c)
  );

  ball_axis #(.LIMIT(Y_MAX), .CENTRE(Y_CENTRE)) u_axis_y (
    .clk_i    (CLK),
    .reset_i  (reset),
    .load_i   (start_i),
    .step_en_i(step_en_c),
    .step_i   (dy_c),
    .pos_o    (ball_y_o),
    .lo_c_o   (y_lo_c),
    .hi_c_o   (y_hi_c)
  );

  // Serve/goal FSM with heading and event pulse registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      theta_q  <= '0;
      speed_q  <= '0;
      active_q <= 1'b0;
      bounce_q <= 1'b0;
      goal_l_q <= 1'b0;
      goal_r_q <= 1'b0;
    end else begin
      bounce_q <= 1'b0;
      goal_l_q <= 1'b0;
      goal_r_q <= 1'b0;
      if (start_i) begin
        state_q  <= MOVE;
        theta_q  <= theta_i;
        speed_q  <= speed_i;
        active_q <= 1'b1;
      end else if (state_q == MOVE) begin
        if (paddle_hit_i) begin
          theta_q  <= reflect_h(theta_q);
          bounce_q <= 1'b1;
        end else if (tick_i) begin
          // Goals win over a simultaneous wall hit and leave the heading alone
          if (x_lo_c || x_hi_c) begin
            goal_l_q <= x_lo_c;
            goal_r_q <= x_hi_c;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end else if (y_lo_c || y_hi_c) begin
            theta_q  <= reflect_v(theta_q);
            bounce_q <= 1'b1;
          end
        end
      end
    end
  end

  assign theta_o      = theta_q;
  assign active_o     = active_q;
  assign bounce_o     = bounce_q;
  assign goal_left_o  = goal_l_q;
  assign goal_right_o = goal_r_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed self-checking bench for ball_motion; the bench drives the LUT returns directly.
module tb_ball_motion;

  logic              CLK = 1'b0;
  logic              reset;
  logic              tick_i, start_i, paddle_hit_i;
  logic [5:0]        theta_i;
  logic [2:0]        speed_i;
  logic signed [7:0] sin_i, cos_i;
  logic [5:0]        theta_o;
  logic [9:0]        ball_x_o, ball_y_o;
  logic              active_o, bounce_o, goal_left_o, goal_right_o;

  int n_checks = 0;
  int n_pass   = 0;

  ball_motion dut (
    .CLK         (CLK),
    .reset       (reset),
    .tick_i      (tick_i),
    .start_i     (start_i),
    .theta_i     (theta_i),
    .speed_i     (speed_i),
    .paddle_hit_i(paddle_hit_i),
    .theta_o     (theta_o),
    .sin_i       (sin_i),
    .cos_i       (cos_i),
    .ball_x_o    (ball_x_o),
    .ball_y_o    (ball_y_o),
    .active_o    (active_o),
    .bounce_o    (bounce_o),
    .goal_left_o (goal_left_o),
    .goal_right_o(goal_right_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One clock with the given strobes; outputs are sampled 1 time unit after the edge
  task automatic cyc(input bit t, input bit p);
    tick_i       = t;
    paddle_hit_i = p;
    @(posedge CLK);
    #1;
    tick_i       = 1'b0;
    paddle_hit_i = 1'b0;
  endtask

  task automatic serve(input int th, input int sp, input bit t);
    start_i = 1'b1;
    theta_i = 6'(th);
    speed_i = 3'(sp);
    cyc(t, 1'b0);
    start_i = 1'b0;
  endtask

  task automatic check_all(input string tag, input int x, input int y, input int th,
                           input int act, input int bnc, input int gl, input int gr);
    check({tag, ".x"}, int'(ball_x_o), x);
    check({tag, ".y"}, int'(ball_y_o), y);
    check({tag, ".theta"}, int'(theta_o), th);
    check({tag, ".active"}, int'(active_o), act);
    check({tag, ".bounce"}, int'(bounce_o), bnc);
    check({tag, ".goal_l"}, int'(goal_left_o), gl);
    check({tag, ".goal_r"}, int'(goal_right_o), gr);
  endtask

  initial begin
    reset = 1'b1; tick_i = 0; start_i = 0; paddle_hit_i = 0;
    theta_i = '0; speed_i = '0; sin_i = '0; cos_i = '0;
    cyc(0, 0);
    cyc(1, 1);
    check_all("reset", 316, 236, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // 1: rightward serve, one tick moves 508/128 px
    cos_i = 8'sd127; sin_i = 8'sd0;
    serve(0, 4, 0);
    check_all("t1.serve", 316, 236, 0, 1, 0, 0, 0);
    cyc(1, 0);
    check_all("t1.tick", 319, 236, 0, 1, 0, 0, 0);

    // 2: upward at speed 7 hits the top wall on tick 34 (30208 - 34*889 < 0)
    cos_i = 8'sd0; sin_i = -8'sd127;
    serve(48, 7, 0);
    for (int k = 1; k <= 33; k++) begin
      cyc(1, 0);
      check("t2.y", int'(ball_y_o), (30208 - 889 * k) / 128);
      check("t2.nobounce", int'(bounce_o), 0);
    end
    cyc(1, 0);
    check_all("t2.wall", 316, 0, 16, 1, 1, 0, 0);
    cyc(0, 0);
    check("t2.pulse_once", int'(bounce_o), 0);
    sin_i = 8'sd127;
    cyc(1, 0);
    check("t2.y_down", int'(ball_y_o), 6);

    // 3: leftward at speed 7 leaves the left edge on tick 46 (40448 - 46*889 < 0)
    cos_i = -8'sd127; sin_i = 8'sd0;
    serve(32, 7, 0);
    for (int k = 1; k <= 45; k++) begin
      cyc(1, 0);
      check("t3.x", int'(ball_x_o), (40448 - 889 * k) / 128);
    end
    cyc(1, 0);
    check_all("t3.goal", 0, 236, 32, 0, 0, 1, 0);
    cyc(1, 1);
    check_all("t3.idle", 0, 236, 32, 0, 0, 0, 0);

    // 4: paddle hit together with a tick reflects and skips the step
    cos_i = 8'sd118; sin_i = 8'sd49;
    serve(4, 7, 0);
    cyc(1, 0);
    check_all("t4.tick", 322, 238, 4, 1, 0, 0, 0);
    cyc(1, 1);
    check_all("t4.paddle", 322, 238, 28, 1, 1, 0, 0);

    // 5a: serve with a tick in MOVE recentres without stepping
    cos_i = 8'sd100; sin_i = 8'sd70;
    serve(10, 5, 1);
    check_all("t5.restart", 316, 236, 10, 1, 0, 0, 0);
    cyc(1, 0);
    check_all("t5.step", 319, 238, 10, 1, 0, 0, 0);

    // 5b: reset mid-flight, paddle pulse in the same cycle is dropped
    reset = 1'b1;
    cyc(1, 1);
    check_all("t5.reset", 316, 236, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(1, 1);
    check_all("t5.idle", 316, 236, 0, 0, 0, 0, 0);

    // speed 0: stationary, no events
    cos_i = -8'sd128; sin_i = -8'sd128;
    serve(40, 0, 0);
    cyc(1, 0);
    check_all("spd0", 316, 236, 40, 1, 0, 0, 0);

    // 6: x and y both go negative on tick 46 -> goal wins, no bounce
    cos_i = -8'sd127; sin_i = -8'sd95;
    serve(56, 7, 0);
    for (int k = 1; k <= 45; k++) cyc(1, 0);
    check("t6.pre_x", int'(ball_x_o), 3);
    check("t6.pre_y", int'(ball_y_o), 2);
    cyc(1, 0);
    check("t6.goal_l", int'(goal_left_o), 1);
    check("t6.bounce", int'(bounce_o), 0);
    check("t6.theta", int'(theta_o), 56);
    check("t6.active", int'(active_o), 0);
    check("t6.x", int'(ball_x_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
